// File: rtl/pc8001_bus_pkg.sv
// Shared types and widths for the PC-8001 main SRAM bus arbiter.
package pc8001_bus_pkg;

    typedef enum logic [2:0] {
        ST_CPU,
        ST_SYNC,
        ST_DMA,
        ST_REL,
        ST_FORCED
    } arb_state_t;

    localparam int unsigned WCNT_W = 5;
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    // Wide enough to hold MAX_BURST itself, so the counter never wraps inside a burst.
    function automatic int unsigned burst_cnt_w(int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/pc8001_bus_arbiter_cpu_wait_gen.sv
// CPU wait-state generator: free-running saturating count since cpu_start,
// compared against the wait limit latched at cpu_start.
module cpu_wait_gen
    import pc8001_bus_pkg::*;
#(
    parameter int unsigned WAIT_SLOW = 25,
    parameter int unsigned WAIT_FAST = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_start,
    input  logic fast,
    output logic wait_active
);

    localparam logic [WCNT_W-1:0] N_SLOW = WCNT_W'(WAIT_SLOW);
    localparam logic [WCNT_W-1:0] N_FAST = WCNT_W'(WAIT_FAST);

    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
            n_q    <= N_SLOW;
        end else if (cpu_start) begin
            wcnt_q <= '0;
            n_q    <= fast ? N_FAST : N_SLOW;
        end else if (wcnt_q != WCNT_MAX) begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    assign wait_active = cpu_start | (wcnt_q < n_q);

endmodule

// File: rtl/pc8001_bus_arbiter.sv
// Main SRAM arbiter: sequences CPU wait states and hands the bus to the CRTC
// text DMA only at CPU bus-cycle boundaries, with a bounded DMA hold time.
module pc8001_bus_arbiter
    import pc8001_bus_pkg::*;
#(
    parameter int unsigned WAIT_SLOW = 25,
    parameter int unsigned WAIT_FAST = 12,
    parameter int unsigned MAX_BURST = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fast,
    input  logic        cpu_start,
    input  logic        cpu_mreq,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_wdata,
    input  logic        lo_we,
    output logic        waitreq,
    input  logic        dma_req,
    input  logic [15:0] dma_adr,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] ram_adr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata
);

    localparam int unsigned BURST_W = burst_cnt_w(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_t         state_q;
    logic [BURST_W-1:0] burst_cnt_q;
    logic               forced_q;
    logic               seen_start_q;
    logic               wait_only;
    logic               owned;

    cpu_wait_gen #(
        .WAIT_SLOW (WAIT_SLOW),
        .WAIT_FAST (WAIT_FAST)
    ) u_wait (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_start   (cpu_start),
        .fast        (fast),
        .wait_active (wait_only)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CPU;
            burst_cnt_q  <= '0;
            forced_q     <= 1'b0;
            seen_start_q <= 1'b0;
            dma_gnt      <= 1'b0;
            dma_rvalid   <= 1'b0;
        end else begin
            dma_rvalid <= dma_gnt;
            unique case (state_q)
                ST_CPU: begin
                    if (dma_req) state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (!dma_req) begin
                        state_q <= ST_CPU;
                    end else if (cpu_start) begin
                        state_q     <= ST_DMA;
                        dma_gnt     <= 1'b1;
                        burst_cnt_q <= '0;
                    end
                end
                ST_DMA: begin
                    burst_cnt_q <= burst_cnt_q + 1'b1;
                    if (!dma_req || burst_cnt_q == BURST_LAST) begin
                        state_q  <= ST_REL;
                        dma_gnt  <= 1'b0;
                        // Still requesting here means the hold limit ended the burst.
                        forced_q <= dma_req;
                    end
                end
                ST_REL: begin
                    state_q      <= forced_q ? ST_FORCED : ST_CPU;
                    seen_start_q <= 1'b0;
                end
                ST_FORCED: begin
                    // First cpu_start opens the guaranteed CPU cycle, the second closes it.
                    if (cpu_start) begin
                        if (seen_start_q) state_q <= dma_req ? ST_SYNC : ST_CPU;
                        else              seen_start_q <= 1'b1;
                    end
                end
                default: state_q <= ST_CPU;
            endcase
        end
    end

    assign owned     = state_q inside {ST_SYNC, ST_DMA, ST_REL};
    assign waitreq   = ~reset_n | wait_only | owned;
    assign ram_adr   = dma_gnt ? dma_adr : cpu_adr;
    assign ram_we    = reset_n & ~dma_gnt & cpu_mreq & cpu_wr & ~cpu_start
                     & (cpu_adr[15] | lo_we);
    assign ram_wdata = cpu_wdata;

endmodule

// File: tb/tb_pc8001_bus_arbiter.sv
// Self-checking bench for pc8001_bus_arbiter: behavioural ownership model plus
// directed timing checks and a randomized soak.
module tb_pc8001_bus_arbiter;

    localparam int WS = 25;
    localparam int WF = 12;
    localparam int MB = 120;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fast = 1'b0;
    logic        cpu_start = 1'b0;
    logic        cpu_mreq = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_adr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        lo_we = 1'b0;
    logic        dma_req = 1'b0;
    logic [15:0] dma_adr = 16'h0000;
    logic        waitreq;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [15:0] ram_adr;
    logic        ram_we;
    logic [7:0]  ram_wdata;

    always #35 clk = ~clk;

    pc8001_bus_arbiter #(
        .WAIT_SLOW (WS),
        .WAIT_FAST (WF),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fast       (fast),
        .cpu_start  (cpu_start),
        .cpu_mreq   (cpu_mreq),
        .cpu_wr     (cpu_wr),
        .cpu_adr    (cpu_adr),
        .cpu_wdata  (cpu_wdata),
        .lo_we      (lo_we),
        .waitreq    (waitreq),
        .dma_req    (dma_req),
        .dma_adr    (dma_adr),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .ram_adr    (ram_adr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata)
    );

    int checks = 0;
    int passes = 0;
    int we_viol = 0;

    // Model: who owns the bus, expressed as flags and counters.
    bit m_pending, m_burst, m_turn, m_turn_forced, m_prev_gnt;
    int m_beats, m_cool, m_wc, m_n;

    logic s_waitreq, s_gnt, s_rvalid, s_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pending = 0; m_burst = 0; m_turn = 0; m_turn_forced = 0; m_prev_gnt = 0;
        m_beats = 0; m_cool = 0; m_wc = 0; m_n = WS;
    endtask

    task automatic model_step();
        m_prev_gnt = m_burst;
        if (cpu_start) begin
            m_wc = 0;
            m_n  = fast ? WF : WS;
        end else if (m_wc < 31) begin
            m_wc++;
        end
        if (m_burst) begin
            if (!dma_req || m_beats == MB) begin
                m_burst = 0; m_turn = 1; m_turn_forced = dma_req;
            end else begin
                m_beats++;
            end
        end else if (m_turn) begin
            m_turn = 0;
            m_cool = m_turn_forced ? 2 : 0;
        end else if (m_cool > 0) begin
            if (cpu_start) begin
                m_cool--;
                if (m_cool == 0) m_pending = dma_req;
            end
        end else if (m_pending) begin
            if (!dma_req) m_pending = 0;
            else if (cpu_start) begin
                m_pending = 0; m_burst = 1; m_beats = 1;
            end
        end else if (dma_req) begin
            m_pending = 1;
        end
    endtask

    // Called at a negedge with this cycle's inputs already driven.
    task automatic tick();
        bit e_wait, e_we;
        logic [15:0] e_adr;
        #1;
        e_wait = cpu_start || (m_wc < m_n) || m_pending || m_burst || m_turn;
        e_we   = !m_burst && cpu_mreq && cpu_wr && !cpu_start && (cpu_adr[15] || lo_we);
        e_adr  = m_burst ? dma_adr : cpu_adr;
        s_waitreq = waitreq; s_gnt = dma_gnt; s_rvalid = dma_rvalid; s_we = ram_we;
        if (dma_gnt && ram_we) we_viol++;
        chk("waitreq", waitreq, e_wait);
        chk("dma_gnt", dma_gnt, m_burst);
        chk("dma_rvalid", dma_rvalid, m_prev_gnt);
        chk("ram_we", ram_we, e_we);
        chk("ram_adr", ram_adr, e_adr);
        chk("ram_wdata", ram_wdata, cpu_wdata);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        #(70 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, gn, rv, first_len, gap, run_len, nruns, last_end;
        bit in_run;
        model_reset();
        cpu_mreq = 1; cpu_wr = 1; cpu_adr = 16'h9000; lo_we = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_waitreq", waitreq, 1);
        chk("rst_gnt", dma_gnt, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_ram_we", ram_we, 0);
        @(negedge clk);
        reset_n = 1; cpu_mreq = 0; cpu_wr = 0; lo_we = 0;

        // Slow and fast wait lengths: clocks from cpu_start until waitreq falls.
        for (int f = 0; f < 2; f++) begin
            cpu_start = 1; fast = (f == 1);
            tick();
            cpu_start = 0; fast = 0;
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (!s_waitreq && lat == 0) lat = k;
            end
            chk(f ? "fast_wait_len" : "slow_wait_len", lat, f ? 13 : 26);
        end

        // Write protection of the low half.
        cpu_mreq = 1; cpu_wr = 1; cpu_wdata = 8'hA5; cpu_adr = 16'h9000; lo_we = 0;
        tick(); chk("we_9000", s_we, 1);
        cpu_adr = 16'h1000;
        tick(); chk("we_1000_locked", s_we, 0);
        lo_we = 1;
        tick(); chk("we_1000_open", s_we, 1);
        cpu_start = 1;
        tick(); chk("we_on_start", s_we, 0);
        cpu_start = 0; cpu_mreq = 0; cpu_wr = 0; lo_we = 0;
        repeat (30) tick();

        // Grant one clock after cpu_start, 80-beat burst.
        dma_req = 1; dma_adr = 16'hC000;
        repeat (3) tick();
        cpu_start = 1;
        tick(); chk("gnt_before_start", s_gnt, 0);
        cpu_start = 0; gn = 0; rv = 0;
        for (int i = 0; i < 200; i++) begin
            dma_adr = 16'($urandom);
            tick();
            if (i == 0) chk("gnt_latency", s_gnt, 1);
            gn += int'(s_gnt); rv += int'(s_rvalid);
            if (gn >= 79) dma_req = 0;
        end
        chk("burst80_gnt", gn, 80);
        chk("burst80_rvalid", rv, 80);

        // Held request: forced release after MB beats, then a CPU cycle, then regrant.
        dma_req = 1; in_run = 0; nruns = 0; first_len = 0; gap = 0; run_len = 0; last_end = 0;
        for (int i = 0; i < 400; i++) begin
            cpu_start = (i % 26 == 0);
            cpu_mreq = 1'($urandom); cpu_wr = 1'($urandom);
            cpu_adr = 16'($urandom); dma_adr = 16'($urandom);
            tick();
            if (s_gnt) begin
                if (!in_run) begin
                    in_run = 1; run_len = 0;
                    if (nruns == 1) gap = i - last_end - 1;
                end
                run_len++;
            end else if (in_run) begin
                in_run = 0; nruns++; last_end = i - 1;
                if (nruns == 1) first_len = run_len;
            end
        end
        chk("forced_first_len", first_len, MB);
        chk("regranted", (nruns >= 2) || (nruns == 1 && in_run), 1);
        chk("forced_gap_ge_cycle", gap >= 26, 1);
        dma_req = 0; cpu_start = 0; cpu_mreq = 0; cpu_wr = 0;
        repeat (60) tick();

        // Request withdrawn before any boundary: no grant.
        gn = 0;
        dma_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); gn += int'(s_gnt);
            if (i == 1) chk("sync_waitreq", s_waitreq, 1);
        end
        dma_req = 0;
        repeat (2) begin tick(); gn += int'(s_gnt); end
        cpu_start = 1;
        tick(); gn += int'(s_gnt);
        cpu_start = 0;
        repeat (3) begin tick(); gn += int'(s_gnt); end
        chk("sync_drop_no_gnt", gn, 0);

        // Asynchronous reset in the middle of a burst.
        dma_req = 1;
        repeat (2) tick();
        cpu_start = 1; tick(); cpu_start = 0;
        repeat (3) tick();
        chk("pre_reset_gnt", s_gnt, 1);
        cpu_mreq = 1; cpu_wr = 1; cpu_adr = 16'h9000; lo_we = 1;
        reset_n = 0;
        #1;
        chk("midburst_rst_gnt", dma_gnt, 0);
        chk("midburst_rst_rvalid", dma_rvalid, 0);
        chk("midburst_rst_we", ram_we, 0);
        chk("midburst_rst_waitreq", waitreq, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1; cpu_mreq = 0; cpu_wr = 0;
        tick(); chk("post_reset_gnt", s_gnt, 0);
        cpu_start = 1; tick(); cpu_start = 0;
        tick(); chk("regrant_after_reset", s_gnt, 1);
        dma_req = 0;
        repeat (5) tick();

        // Randomized soak.
        for (int i = 0; i < 5000; i++) begin
            cpu_start = ($urandom_range(0, 9) == 0);
            fast      = 1'($urandom);
            if ($urandom_range(0, 149) == 0) dma_req = ~dma_req;
            cpu_mreq  = 1'($urandom); cpu_wr = 1'($urandom); lo_we = 1'($urandom);
            cpu_adr   = 16'($urandom); cpu_wdata = 8'($urandom); dma_adr = 16'($urandom);
            tick();
        end
        chk("no_we_during_gnt", we_viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
